// File: rtl/conv_window.sv
// 5x5 window builder behind the BRAM line delay: column shift pipeline with
// horizontal border handling. Define BORDER_CLAMP_EN for replicate-edge clamping; otherwise out-of-line columns read as zero.
module conv_window #(
    parameter int STAT_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        pa,
    input  logic [7:0]        pb,
    input  logic [7:0]        pc,
    input  logic [7:0]        pd,
    input  logic [7:0]        pe,
    input  logic [STAT_W-1:0] stat_i,
    output logic [199:0]      win_o,
    output logic [STAT_W-1:0] stat_o,
    output logic              valid_o
);

    // s[k] is a full column {pe,pd,pc,pb,pa}; s[0] is the newest (rightmost).
    logic [4:0][39:0]          s;
    logic [4:0]                d;
    logic [2:0][STAT_W-1:0]    stat_q;
    logic [4:0][39:0]          col;
    logic [199:0]              win_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            s       <= '0;
            d       <= '0;
            stat_q  <= '0;
            win_o   <= '0;
            stat_o  <= '0;
            valid_o <= 1'b0;
        end else begin
            s[0]    <= {pe, pd, pc, pb, pa};
            for (int k = 1; k < 5; k++) s[k] <= s[k-1];
            d       <= {d[3:0], stat_i[0]};
            stat_q[0] <= stat_i;
            stat_q[1] <= stat_q[0];
            stat_q[2] <= stat_q[1];
            stat_o  <= stat_q[2];
            win_o   <= win_next;
            valid_o <= d[2];
        end
    end

    // col[c] is window column c (c0 leftmost); nominal mapping is s[4-c].
    always_comb begin
        for (int c = 0; c < 5; c++) col[c] = s[4-c];
`ifdef BORDER_CLAMP_EN
        if (!d[3]) begin
            col[1] = s[2];
            col[0] = s[2];
        end else if (!d[4]) begin
            col[0] = s[3];
        end
        if (!d[1]) begin
            col[3] = s[2];
            col[4] = s[2];
        end else if (!d[0]) begin
            col[4] = s[1];
        end
`else
        // A column is outside the line if any DE gap sits between it and the centre.
        if (!d[3]) begin
            col[1] = '0;
            col[0] = '0;
        end else if (!d[4]) begin
            col[0] = '0;
        end
        if (!d[1]) begin
            col[3] = '0;
            col[4] = '0;
        end else if (!d[0]) begin
            col[4] = '0;
        end
`endif
    end

    always_comb begin
        win_next = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                win_next[8*(5*r+c) +: 8] = col[c][8*r +: 8];
        if (!d[2]) win_next = '0;
    end

endmodule

// File: tb/tb_conv_window.sv
// Directed bench for conv_window: reset, latency, borders, short lines, status pulses.
module tb_conv_window;

    logic         clk;
    logic         rst;
    logic [7:0]   pa, pb, pc, pd, pe;
    logic [2:0]   stat_i;
    logic [199:0] win_o;
    logic [2:0]   stat_o;
    logic         valid_o;

    conv_window #(.STAT_W(3)) dut (
        .clk(clk), .rst(rst),
        .pa(pa), .pb(pb), .pc(pc), .pd(pd), .pe(pe),
        .stat_i(stat_i), .win_o(win_o), .stat_o(stat_o), .valid_o(valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vecs  = 0;
    int fails = 0;
    int n     = 0;
    int off [5] = '{100, 50, 0, 120, 170};

    logic [199:0] log_win   [256];
    logic [2:0]   log_stat  [256];
    logic         log_valid [256];
    logic [2:0]   in_stat   [256];

    task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Row r of tap value v: pa=v+100, pb=v+50, pc=v, pd=v+120, pe=v+170.
    task automatic cycle(input logic r, input logic [2:0] st, input logic [7:0] v);
        rst = r; stat_i = st;
        pa = 8'(v + 8'd100); pb = 8'(v + 8'd50); pc = v;
        pd = 8'(v + 8'd120); pe = 8'(v + 8'd170);
        in_stat[n] = st;
        @(posedge clk);
        #1;
        log_win[n] = win_o; log_stat[n] = stat_o; log_valid[n] = valid_o;
        n++;
    endtask

    // Packs row r as {c0,c1,c2,c3,c4} for readable expectations.
    function automatic logic [39:0] row_of(input logic [199:0] w, input int r);
        logic [39:0] res;
        for (int c = 0; c < 5; c++) res[8*(4-c) +: 8] = w[8*(5*r+c) +: 8];
        return res;
    endfunction

    initial begin
        int p, a0, b0, c0, vcnt;
        logic [199:0] full;
        logic [39:0]  rexp;
        logic [7:0]   rv;
        int widths [4] = '{2, 20, 3, 5};
        logic [2:0] bits [4] = '{3'd2, 3'd2, 3'd4, 3'd6};

        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 3'd7, 8'd99);
            check("reset_win", log_win[n-1], '0);
            check("reset_stat", {197'd0, log_stat[n-1]}, '0);
            check("reset_valid", {199'd0, log_valid[n-1]}, '0);
        end
        p = n;
        cycle(1'b0, 3'd7, 8'd99);
        check("post_reset_win", log_win[p], '0);
        check("post_reset_stat", {197'd0, log_stat[p]}, '0);
        check("post_reset_valid", {199'd0, log_valid[p]}, '0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 3'd0, 8'd0);

        a0 = n;
        for (int i = 0; i < 10; i++) cycle(1'b0, 3'd1, 8'(10 + i));
        for (int i = 0; i < 6; i++) cycle(1'b0, 3'd0, 8'd0);
        b0 = n;
        cycle(1'b0, 3'd1, 8'd50);
        for (int i = 0; i < 6; i++) cycle(1'b0, 3'd0, 8'd0);
        c0 = n;
        cycle(1'b0, 3'd1, 8'd60);
        cycle(1'b0, 3'd1, 8'd61);
        for (int i = 0; i < 6; i++) cycle(1'b0, 3'd0, 8'd0);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < widths[k]; i++) cycle(1'b0, bits[k], 8'(n));
            for (int i = 0; i < 4; i++) cycle(1'b0, 3'd0, 8'(n));
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 3'd0, 8'd0);

        check("lat_centre", {192'd0, log_win[a0+3][8*12 +: 8]}, 200'd10);
        check("gap_before", log_win[a0+2], '0);
        check("gap_after", log_win[a0+13], '0);
        vcnt = 0;
        for (int i = a0; i < b0; i++) vcnt += int'(log_valid[i]);
        check("valid_count", 200'(vcnt), 200'd10);

        full = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                full[8*(5*r+c) +: 8] = 8'(12 + c + off[r]);
        check("full_window", log_win[a0+7], full);

`ifdef BORDER_CLAMP_EN
        check("left_w0", {160'd0, row_of(log_win[a0+3], 2)}, {160'd0, 8'd10, 8'd10, 8'd10, 8'd11, 8'd12});
        check("left_w1", {160'd0, row_of(log_win[a0+4], 2)}, {160'd0, 8'd10, 8'd10, 8'd11, 8'd12, 8'd13});
        check("right_w8", {160'd0, row_of(log_win[a0+11], 2)}, {160'd0, 8'd16, 8'd17, 8'd18, 8'd19, 8'd19});
        check("right_w9", {160'd0, row_of(log_win[a0+12], 2)}, {160'd0, 8'd17, 8'd18, 8'd19, 8'd19, 8'd19});
        check("left_row0", {160'd0, row_of(log_win[a0+3], 0)}, {160'd0, 8'd110, 8'd110, 8'd110, 8'd111, 8'd112});
        check("two_px_w0", {160'd0, row_of(log_win[c0+3], 2)}, {160'd0, 8'd60, 8'd60, 8'd60, 8'd61, 8'd61});
        check("two_px_w1", {160'd0, row_of(log_win[c0+4], 2)}, {160'd0, 8'd60, 8'd60, 8'd61, 8'd61, 8'd61});
`else
        check("left_w0", {160'd0, row_of(log_win[a0+3], 2)}, {160'd0, 8'd0, 8'd0, 8'd10, 8'd11, 8'd12});
        check("left_w1", {160'd0, row_of(log_win[a0+4], 2)}, {160'd0, 8'd0, 8'd10, 8'd11, 8'd12, 8'd13});
        check("right_w8", {160'd0, row_of(log_win[a0+11], 2)}, {160'd0, 8'd16, 8'd17, 8'd18, 8'd19, 8'd0});
        check("right_w9", {160'd0, row_of(log_win[a0+12], 2)}, {160'd0, 8'd17, 8'd18, 8'd19, 8'd0, 8'd0});
        check("left_row0", {160'd0, row_of(log_win[a0+3], 0)}, {160'd0, 8'd0, 8'd0, 8'd110, 8'd111, 8'd112});
        check("two_px_w0", {160'd0, row_of(log_win[c0+3], 2)}, {160'd0, 8'd0, 8'd0, 8'd60, 8'd61, 8'd0});
        check("two_px_w1", {160'd0, row_of(log_win[c0+4], 2)}, {160'd0, 8'd0, 8'd60, 8'd61, 8'd0, 8'd0});
`endif

        for (int r = 0; r < 5; r++) begin
            rv = 8'(50 + off[r]);
`ifdef BORDER_CLAMP_EN
            rexp = {5{rv}};
`else
            rexp = {8'd0, 8'd0, rv, 8'd0, 8'd0};
`endif
            check($sformatf("one_px_row%0d", r), {160'd0, row_of(log_win[b0+3], r)}, {160'd0, rexp});
        end
        check("one_px_before", log_win[b0+2], '0);
        check("one_px_after", log_win[b0+4], '0);

        for (int i = p; i + 3 < n; i++) begin
            check($sformatf("stat_delay_%0d", i), {197'd0, log_stat[i+3]}, {197'd0, in_stat[i]});
            check($sformatf("valid_delay_%0d", i), {199'd0, log_valid[i+3]}, {199'd0, in_stat[i][0]});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
